// File: rtl/control_unit.sv
`default_nettype none
// ============================================================================
// Module   : control_unit
// Brief    : Microcode sequencer of the 8-bit CPU. Tracks the T-state,
//            decodes the opcode nibble and drives the 16-bit control word.
// Revision : 1.0  initial release
// ============================================================================
module control_unit #(
   parameter int STEP_WIDTH = 3
) (
   input  logic                  i_clk,
   input  logic                  i_reset,
   input  logic                  i_clke,
   input  logic [3:0]            i_opcode,
   input  logic                  i_flag_c,
   input  logic                  i_flag_z,
   output logic [STEP_WIDTH-1:0] o_step,
   output logic                  o_halted,
   output logic                  o_hlt,
   output logic                  o_mi,
   output logic                  o_ri,
   output logic                  o_ro,
   output logic                  o_io,
   output logic                  o_ii,
   output logic                  o_ai,
   output logic                  o_ao,
   output logic                  o_eo,
   output logic                  o_su,
   output logic                  o_bi,
   output logic                  o_oi,
   output logic                  o_ce,
   output logic                  o_co,
   output logic                  o_j,
   output logic                  o_fi
);

   // T-state encoding; the step counter is the sequencer state
   localparam logic [STEP_WIDTH-1:0] c_step_t0  = STEP_WIDTH'(0);
   localparam logic [STEP_WIDTH-1:0] c_step_t1  = STEP_WIDTH'(1);
   localparam logic [STEP_WIDTH-1:0] c_step_t2  = STEP_WIDTH'(2);
   localparam logic [STEP_WIDTH-1:0] c_step_t3  = STEP_WIDTH'(3);
   localparam logic [STEP_WIDTH-1:0] c_step_t4  = STEP_WIDTH'(4);
   localparam logic [STEP_WIDTH-1:0] c_step_one = STEP_WIDTH'(1);

   // Control word bit assignments
   localparam logic [15:0] c_cw_hlt = 16'h8000;
   localparam logic [15:0] c_cw_mi  = 16'h4000;
   localparam logic [15:0] c_cw_ri  = 16'h2000;
   localparam logic [15:0] c_cw_ro  = 16'h1000;
   localparam logic [15:0] c_cw_io  = 16'h0800;
   localparam logic [15:0] c_cw_ii  = 16'h0400;
   localparam logic [15:0] c_cw_ai  = 16'h0200;
   localparam logic [15:0] c_cw_ao  = 16'h0100;
   localparam logic [15:0] c_cw_eo  = 16'h0080;
   localparam logic [15:0] c_cw_su  = 16'h0040;
   localparam logic [15:0] c_cw_bi  = 16'h0020;
   localparam logic [15:0] c_cw_oi  = 16'h0010;
   localparam logic [15:0] c_cw_ce  = 16'h0008;
   localparam logic [15:0] c_cw_co  = 16'h0004;
   localparam logic [15:0] c_cw_j   = 16'h0002;
   localparam logic [15:0] c_cw_fi  = 16'h0001;

   // Opcodes
   localparam logic [3:0] c_op_lda = 4'b0001;
   localparam logic [3:0] c_op_add = 4'b0010;
   localparam logic [3:0] c_op_sub = 4'b0011;
   localparam logic [3:0] c_op_sta = 4'b0100;
   localparam logic [3:0] c_op_ldi = 4'b0101;
   localparam logic [3:0] c_op_jmp = 4'b0110;
   localparam logic [3:0] c_op_jc  = 4'b0111;
   localparam logic [3:0] c_op_jz  = 4'b1000;
   localparam logic [3:0] c_op_out = 4'b1110;
   localparam logic [3:0] c_op_hlt = 4'b1111;

   logic [STEP_WIDTH-1:0] r_step;
   logic                  r_halted;
   logic [STEP_WIDTH-1:0] w_next_step;
   logic                  w_next_halted;
   logic [STEP_WIDTH-1:0] w_step_inc;
   logic [15:0]           w_word;

   // Microcode ROM: control word for a given step, opcode and flag state
   function automatic logic [15:0] f_ctrl_word(
      input logic [STEP_WIDTH-1:0] step,
      input logic [3:0]            op,
      input logic                  flag_c,
      input logic                  flag_z
   );
      logic [15:0] word;
      word = 16'h0000;
      case (step)
         c_step_t0: word = c_cw_co | c_cw_mi;
         c_step_t1: word = c_cw_ro | c_cw_ii | c_cw_ce;
         c_step_t2: begin
            case (op)
               c_op_lda, c_op_add, c_op_sub, c_op_sta: word = c_cw_io | c_cw_mi;
               c_op_ldi: word = c_cw_io | c_cw_ai;
               c_op_jmp: word = c_cw_io | c_cw_j;
               c_op_jc:  word = flag_c ? (c_cw_io | c_cw_j) : 16'h0000;
               c_op_jz:  word = flag_z ? (c_cw_io | c_cw_j) : 16'h0000;
               c_op_out: word = c_cw_ao | c_cw_oi;
               c_op_hlt: word = c_cw_hlt;
               default:  word = 16'h0000;
            endcase
         end
         c_step_t3: begin
            case (op)
               c_op_lda:           word = c_cw_ro | c_cw_ai;
               c_op_add, c_op_sub: word = c_cw_ro | c_cw_bi;
               c_op_sta:           word = c_cw_ao | c_cw_ri;
               default:            word = 16'h0000;
            endcase
         end
         c_step_t4: begin
            case (op)
               c_op_add: word = c_cw_eo | c_cw_ai | c_cw_fi;
               c_op_sub: word = c_cw_eo | c_cw_ai | c_cw_su | c_cw_fi;
               default:  word = 16'h0000;
            endcase
         end
         default: word = 16'h0000;
      endcase
      return word;
   endfunction

   assign w_step_inc = r_step + c_step_one;

   // State register: reset and advance only on enabled edges
   always_ff @(posedge i_clk) begin
      if (i_clke) begin
         if (i_reset) begin
            r_step   <= c_step_t0;
            r_halted <= 1'b0;
         end else begin
            r_step   <= w_next_step;
            r_halted <= w_next_halted;
         end
      end
   end

   // Next-state: skip to T0 early when the following microstep is empty
   always_comb begin
      w_next_step   = r_step;
      w_next_halted = r_halted;
      if (!r_halted) begin
         case (r_step)
            c_step_t0: w_next_step = c_step_t1;
            // IR is loaded on this edge, so the opcode cannot be looked ahead
            c_step_t1: w_next_step = c_step_t2;
            c_step_t2, c_step_t3: begin
               if ((r_step == c_step_t2) && (i_opcode == c_op_hlt)) begin
                  w_next_halted = 1'b1;
               end else if (f_ctrl_word(w_step_inc, i_opcode, i_flag_c, i_flag_z) == 16'h0000) begin
                  w_next_step = c_step_t0;
               end else begin
                  w_next_step = w_step_inc;
               end
            end
            default: w_next_step = c_step_t0;
         endcase
      end
   end

   // Output decode: halted state forces a lone HLT
   always_comb begin
      w_word = f_ctrl_word(r_step, i_opcode, i_flag_c, i_flag_z);
      if (r_halted) begin
         w_word = c_cw_hlt;
      end
   end

   assign o_step   = r_step;
   assign o_halted = r_halted;
   assign {o_hlt, o_mi, o_ri, o_ro, o_io, o_ii, o_ai, o_ao,
           o_eo, o_su, o_bi, o_oi, o_ce, o_co, o_j, o_fi} = w_word;

endmodule
`default_nettype wire

// File: tb/tb_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_control_unit
// Brief    : Directed self-checking bench for the microcode sequencer.
// Revision : 1.0  initial release
// ============================================================================
module tb_control_unit;

   localparam logic [15:0] HLT = 16'h8000, MI = 16'h4000, RI = 16'h2000, RO = 16'h1000;
   localparam logic [15:0] IO  = 16'h0800, II = 16'h0400, AI = 16'h0200, AO = 16'h0100;
   localparam logic [15:0] EO  = 16'h0080, SU = 16'h0040, BI = 16'h0020, OI = 16'h0010;
   localparam logic [15:0] CE  = 16'h0008, CO = 16'h0004, J  = 16'h0002, FI = 16'h0001;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       clke = 1'b1;
   logic [3:0] opcode = 4'h0;
   logic       flag_c = 1'b0;
   logic       flag_z = 1'b0;
   logic [2:0] step;
   logic       halted;
   logic hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi;
   logic [15:0] word;

   int n_tests = 0;
   int n_fail  = 0;

   control_unit #(.STEP_WIDTH(3)) dut (
      .i_clk(clk), .i_reset(reset), .i_clke(clke), .i_opcode(opcode),
      .i_flag_c(flag_c), .i_flag_z(flag_z), .o_step(step), .o_halted(halted),
      .o_hlt(hlt), .o_mi(mi), .o_ri(ri), .o_ro(ro), .o_io(io), .o_ii(ii),
      .o_ai(ai), .o_ao(ao), .o_eo(eo), .o_su(su), .o_bi(bi), .o_oi(oi),
      .o_ce(ce), .o_co(co), .o_j(j), .o_fi(fi)
   );

   assign word = {hlt, mi, ri, ro, io, ii, ai, ao, eo, su, bi, oi, ce, co, j, fi};

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk_state(input string tag, input logic [2:0] exp_step,
                            input logic [15:0] exp_word, input logic exp_halted);
      check({tag, "/step"}, 16'(step), 16'(exp_step));
      check({tag, "/word"}, word, exp_word);
      check({tag, "/halted"}, 16'(halted), 16'(exp_halted));
   endtask

   // One full instruction from T0; junk opcode during fetch must not matter
   task automatic run_instr(input string tag, input logic [3:0] op, input logic c,
                            input logic z, input logic [15:0] w2, input logic [15:0] w3,
                            input logic [15:0] w4);
      flag_c = c;
      flag_z = z;
      opcode = ~op;
      #1;
      chk_state({tag, "/T0"}, 3'd0, CO | MI, 1'b0);
      tick();
      chk_state({tag, "/T1"}, 3'd1, RO | II | CE, 1'b0);
      tick();
      opcode = op;
      #1;
      chk_state({tag, "/T2"}, 3'd2, w2, 1'b0);
      tick();
      if (w3 != 16'h0000) begin
         chk_state({tag, "/T3"}, 3'd3, w3, 1'b0);
         tick();
         if (w4 != 16'h0000) begin
            chk_state({tag, "/T4"}, 3'd4, w4, 1'b0);
            tick();
         end
      end
      check({tag, "/end"}, 16'(step), 16'd0);
   endtask

   initial begin
      // Reset
      reset = 1'b1;
      clke  = 1'b1;
      tick();
      tick();
      reset = 1'b0;
      chk_state("reset", 3'd0, CO | MI, 1'b0);

      // Every opcode family, including flag-dependent jumps and undefined ones
      run_instr("lda",   4'b0001, 1'b0, 1'b0, IO | MI, RO | AI, 16'h0);
      run_instr("add",   4'b0010, 1'b0, 1'b0, IO | MI, RO | BI, EO | AI | FI);
      run_instr("sub",   4'b0011, 1'b0, 1'b0, IO | MI, RO | BI, EO | AI | SU | FI);
      run_instr("sta",   4'b0100, 1'b0, 1'b0, IO | MI, AO | RI, 16'h0);
      run_instr("ldi",   4'b0101, 1'b0, 1'b0, IO | AI, 16'h0, 16'h0);
      run_instr("jmp",   4'b0110, 1'b0, 1'b0, IO | J, 16'h0, 16'h0);
      run_instr("jc1",   4'b0111, 1'b1, 1'b0, IO | J, 16'h0, 16'h0);
      run_instr("jc0",   4'b0111, 1'b0, 1'b1, 16'h0, 16'h0, 16'h0);
      run_instr("jz1",   4'b1000, 1'b0, 1'b1, IO | J, 16'h0, 16'h0);
      run_instr("jz0",   4'b1000, 1'b1, 1'b0, 16'h0, 16'h0, 16'h0);
      run_instr("out",   4'b1110, 1'b0, 1'b0, AO | OI, 16'h0, 16'h0);
      run_instr("nop",   4'b0000, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
      run_instr("und9",  4'b1001, 1'b1, 1'b1, 16'h0, 16'h0, 16'h0);
      run_instr("und10", 4'b1010, 1'b0, 1'b0, 16'h0, 16'h0, 16'h0);
      run_instr("und13", 4'b1101, 1'b1, 1'b1, 16'h0, 16'h0, 16'h0);

      // Clock enable low freezes everything, including a held reset
      opcode = 4'b0001;
      flag_c = 1'b0;
      flag_z = 1'b0;
      tick();
      tick();
      tick();
      chk_state("ce/pre", 3'd3, RO | AI, 1'b0);
      reset = 1'b1;
      clke  = 1'b0;
      for (int k = 0; k < 3; k++) begin
         tick();
         chk_state("ce/frozen", 3'd3, RO | AI, 1'b0);
      end
      clke = 1'b1;
      tick();
      reset = 1'b0;
      chk_state("ce/reset", 3'd0, CO | MI, 1'b0);

      // Halt latches at T2, then only reset releases it
      opcode = 4'b1111;
      tick();
      tick();
      chk_state("hlt/T2", 3'd2, HLT, 1'b0);
      for (int k = 0; k < 12; k++) begin
         tick();
         opcode = 4'(k);
         flag_c = ~flag_c;
         #1;
         chk_state("hlt/frozen", 3'd2, HLT, 1'b1);
      end
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk_state("hlt/reset", 3'd0, CO | MI, 1'b0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/control_unit.md
# control_unit

Microcode sequencer of the 8-bit CPU. It tracks the T-state of the current instruction and decodes the opcode nibble from the instruction register. It drives the write enables (`i_we`) of the A, B, IR, MAR and OUT registers, plus the bus-output selects, program-counter, RAM and flags controls. It sits directly upstream of the register file and bus mux, and is advanced by the same `i_clk` and `i_clke` pair.

## Interface
Parameters:
- `STEP_WIDTH`, 3: width of the T-state counter. The maximum step is fixed at 4.

Ports:
- `i_clk`  in  1  clock.
- `i_reset`  in  1  synchronous, active-high reset.
- `i_clke`  in  1  clock enable. State updates only on edges with `i_clke`=1.
- `i_opcode`  in  4  IR[7:4], the registered IR output.
- `i_flag_c`  in  1  registered carry flag.
- `i_flag_z`  in  1  registered zero flag.
- `o_step`  out  3  current T-state, 0..4.
- `o_halted`  out  1  halt latch.
- `o_hlt`, `o_mi`, `o_ri`, `o_ro`, `o_io`, `o_ii`, `o_ai`, `o_ao`, `o_eo`, `o_su`, `o_bi`, `o_oi`, `o_ce`, `o_co`, `o_j`, `o_fi`  out  1 each  control word (16 bits):
  - halt;
  - MAR in;
  - RAM in / out;
  - IR out (low nibble) / IR in;
  - A in / out;
  - ALU out / subtract;
  - B in;
  - OUT in;
  - PC enable / out / jump;
  - flags in.

## Operation
- State:
  - `step` (3b), reset 0.
  - `halted` (1b), reset 0.
- Reset takes effect on a rising edge with `i_clke`=1 and `i_reset`=1, consistent with the register blocks. Reset has priority over halt and step advance.
- Control outputs are combinational from `step`, `i_opcode`, `i_flag_c`, `i_flag_z`, `halted`. Out of reset the word is step 0: `o_co`=`o_mi`=1, all others 0, `o_halted`=0, `o_step`=0.
- Fetch, opcode ignored:
  - T0: CO MI.
  - T1: RO II CE.
- Execute (T2/T3/T4):
  - 0000 NOP: –
  - 0001 LDA: IO MI / RO AI
  - 0010 ADD: IO MI / RO BI / EO AI FI
  - 0011 SUB: IO MI / RO BI / EO AI SU FI
  - 0100 STA: IO MI / AO RI
  - 0101 LDI: IO AI
  - 0110 JMP: IO J
  - 0111 JC: IO J if `i_flag_c`, else –
  - 1000 JZ: IO J if `i_flag_z`, else –
  - 1110 OUT: AO OI
  - 1111 HLT: HLT
  - 1001–1101: treated as NOP.
- Next step, evaluated on `i_clke` edges when not halted:
  - step 0 → 1.
  - step 1 → 2 unconditionally. IR is written on this same edge, so no look-ahead decode.
  - step 2..3 → 0 if the step+1 word for the current opcode and flags is all-zero, else step+1.
  - step 4 → 0.
- Zero words at T2 (NOP, untaken JC/JZ, undefined opcodes) execute as one idle cycle.
- Halt:
  - At step 2 with opcode 1111, `o_hlt`=1. On the next enabled edge, `halted`←1 and `step` stays 2.
  - While `halted`=1: `o_hlt`=1, all other controls 0, `step` frozen. Only reset clears it.

## Timing
- Each step lasts exactly one enabled clock. Cycles with `i_clke`=0 change nothing, including reset.
- Instruction lengths in enabled cycles:
  - NOP/undef 3, LDA 4, ADD/SUB 5, STA 4, LDI 3, JMP 3;
  - JC/JZ 3 whether taken or not;
  - OUT 3;
  - HLT 3, then frozen.
- Flags are sampled combinationally during T2. A flags update from the immediately preceding ADD T4 (FI) is visible because `i_flag_*` are registered.
- Reset mid-instruction, at any step or while halted: next state is step 0, `halted`=0. The control word is CO MI in the cycle after the edge.
- Opcode changes while step < 2 have no effect on outputs or sequencing.
- `step` never exceeds 4 and never takes the values 5–7.

## Test plan
- Reset then 4 enabled cycles with opcode 0001 presented from T2: outputs per step are {CO,MI}, {RO,II,CE}, {IO,MI}, {RO,AI}; `o_step`=0,1,2,3, then 0.
- ADD (0010), then SUB (0011) back to back: step sequence 0,1,2,3,4,0,1,2,3,4,0. T4 words are {EO,AI,FI} and {EO,AI,SU,FI}.
- JC with `i_flag_c`=1: T2={IO,J}. Same with `i_flag_c`=0: T2 all-zero. Both return to step 0 after T2. Repeat with JZ on `i_flag_z`.
- Toggle `i_clke` low for 3 cycles mid-LDA at step 3 with `i_reset`=1 held: `o_step` stays 3 and outputs are unchanged. Raising `i_clke` gives step 0.
- HLT (1111): T2 `o_hlt`=1. Afterwards `o_halted`=1, `o_step`=2 and only `o_hlt` is asserted for 10+ enabled cycles. Reset returns step 0 with {CO,MI}.
- Opcode 1010 (undefined) and 0000: sequence 0,1,2(idle),0. No control asserted at T2.
